enc_2of5_tx: RTL and testbench
==============================

# enc_2of5_tx

- Encodes a BCD digit (0–9) into a 2-of-5 code word and transmits it serially as a framed bit stream.
- Also presents the word in parallel, for local display or loopback.
- Source side of the 2-of-5 link: its serial and parallel words are exactly what the 2-of-5 display decoder consumes on its E1..E5 inputs.
- Out-of-range digits produce a deliberately invalid word, so the far end shows its error pattern.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit. Legal values are ≥ 2.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- digit  in  4  BCD digit to send
- in_valid  in  1  digit is valid
- in_ready  out  1  block can accept a digit
- code_out  out  5  last encoded word {E1,E2,E3,E4,E5}
- tx  out  1  serial line; idles high
- busy  out  1  a frame is in progress
- err  out  1  one-cycle pulse when a non-BCD digit is accepted

## Operation
Code table (weights 7-4-2-1-0, word = {E1..E5}):
- 0=11000, 1=00011, 2=00101, 3=00110, 4=01001
- 5=01010, 6=01100, 7=10001, 8=10010, 9=10100
- Digits 10–15 encode to 00000 (zero hot = invalid) and assert err.

Handshake:
- Accept occurs when in_valid && in_ready at a rising edge.
- in_ready = 1 only in IDLE (and not in reset).
- in_valid while not ready is ignored; no queueing.

On accept:
- code_out and the shift register load the encoded word.
- err pulses for that one cycle if the digit is > 9.

code_out holds its value until the next accept.

Frame sent on tx: start bit 0, then E1, E2, E3, E4, E5 (E1 first), then stop bit 1. Each bit lasts CLKS_PER_BIT cycles.

FSM:
- IDLE → START on accept.
- START → DATA after CLKS_PER_BIT cycles.
- DATA → STOP after 5 bit periods.
- STOP → IDLE after CLKS_PER_BIT cycles.

busy = (state != IDLE).

Reset values: state IDLE, tx=1, code_out=00000, busy=0, in_ready=0 during reset, err=0, all counters 0.

## Timing
- Accept at edge k:
  - From k+1: tx=0, busy=1, in_ready=0, code_out valid.
  - Data bit i (i=0..4) occupies cycles k+1+(i+1)·CLKS_PER_BIT … +CLKS_PER_BIT−1.
  - Stop bit follows the data bits.
  - Returns to IDLE (in_ready=1) at k+1+7·CLKS_PER_BIT.
- Frame length is exactly 7·CLKS_PER_BIT cycles.
- Back-to-back transfer: if in_valid is held, the next accept occurs on the first IDLE cycle. Minimum digit period is 7·CLKS_PER_BIT+1 cycles.
- Reset asserted mid-frame: at the next edge tx=1, state IDLE, code_out=00000. The partial frame is abandoned.
- Reset is not required at power-up beyond one cycle. Outputs are don't-care before the first reset edge.

## Structure
- Shared package `pkg_2of5`:
  - state enum (IDLE, START, DATA, STOP)
  - constants FRAME_BITS=7 and WORD_BITS=5
  - pure function `enc_2of5(digit)` returning the 5-bit word
- The decoder-side verification model reuses the same package, so the table is defined once.
- One sub-module, `bit_tick_gen`: a counter 0..CLKS_PER_BIT−1 that emits `tick` on wrap. It is cleared on accept and on reset.
- The top level holds:
  - FSM
  - 3-bit bit-index counter (0..4)
  - 5-bit shift register
  - code_out register

## Test plan
- Reset, then idle 20 cycles → tx=1, busy=0, in_ready=1, code_out=00000, err never asserted.
- CLKS_PER_BIT=4, send digit 7 → code_out=10001 from accept+1; tx sequence per 4-cycle bit is 0,1,0,0,0,1,1; in_ready returns 29 cycles after accept.
- Sweep digits 0–9 back-to-back with in_valid held high → each frame decodes to its table word; every word has exactly two ones; no gaps beyond one IDLE cycle between frames.
- Send digit 12 → err high for exactly 1 cycle; code_out=00000; frame data bits all 0; stop bit 1.
- Pulse in_valid with digit 3 while busy → ignored; code_out unchanged; no second frame.
- Assert rst_n=0 during data bit 2 of digit 5 → next edge tx=1, busy=0, code_out=00000; after release, a new digit 1 sends 00011 cleanly.

Source files
------------

// File: rtl/pkg_2of5.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkg_2of5 : shared 2-of-5 code table, FSM states and frame constants   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pkg_2of5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 7;
  localparam int WORD_BITS  = 5;

  // Weights 7-4-2-1-0; zero is the odd one out at 7+4. Non-BCD gives zero-hot.
  function automatic logic [WORD_BITS-1:0] enc_2of5(input logic [3:0] digit);
    logic [WORD_BITS-1:0] w_word;
    case (digit)
      4'd0:    w_word = 5'b11000;
      4'd1:    w_word = 5'b00011;
      4'd2:    w_word = 5'b00101;
      4'd3:    w_word = 5'b00110;
      4'd4:    w_word = 5'b01001;
      4'd5:    w_word = 5'b01010;
      4'd6:    w_word = 5'b01100;
      4'd7:    w_word = 5'b10001;
      4'd8:    w_word = 5'b10010;
      4'd9:    w_word = 5'b10100;
      default: w_word = 5'b00000;
    endcase
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_tick_gen : bit-period counter, tick on the last cycle of a bit    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

  logic [c_cnt_w-1:0] r_cnt;

  assign tick = (r_cnt == c_cnt_w'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/enc_2of5_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | enc_2of5_tx : BCD to 2-of-5 encoder with framed serial transmitter    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module enc_2of5_tx
  import pkg_2of5::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           digit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_BITS-1:0] code_out,
  output logic                 tx,
  output logic                 busy,
  output logic                 err
);

  state_t               r_state;
  logic [2:0]           r_bit_idx;
  logic [WORD_BITS-1:0] r_shift;
  logic [WORD_BITS-1:0] r_code;
  logic                 r_tx;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_tick;
  logic [WORD_BITS-1:0] w_word;

  assign in_ready = rst_n && (r_state == IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_word   = enc_2of5(digit);
  assign busy     = (r_state != IDLE);
  assign tx       = r_tx;
  assign code_out = r_code;
  assign err      = r_err;

  // Restarting the divider on accept aligns every bit period to the start bit.
  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_accept),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_code    <= '0;
      r_tx      <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= START;
            r_code    <= w_word;
            r_shift   <= w_word;
            r_tx      <= 1'b0;
            r_bit_idx <= '0;
            r_err     <= (digit > 4'd9);
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_tx    <= r_shift[WORD_BITS-1];
            r_shift <= {r_shift[WORD_BITS-2:0], 1'b0};
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'(WORD_BITS - 1)) begin
              r_state   <= STOP;
              r_tx      <= 1'b1;
              r_bit_idx <= '0;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[WORD_BITS-1];
              r_shift   <= {r_shift[WORD_BITS-2:0], 1'b0};
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enc_2of5_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_enc_2of5_tx : directed + random checks against a weight-sum model  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_enc_2of5_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] code_out;
  logic       tx;
  logic       busy;
  logic       err;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 0;
  int cyc     = 0;

  // reference model state
  bit         m_active = 0;
  int         m_pos    = 0;
  logic [4:0] m_code   = '0;
  bit         m_err    = 0;

  enc_2of5_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .digit   (digit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .code_out(code_out),
    .tx      (tx),
    .busy    (busy),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Word = the two weights (7,4,2,1,0) that sum to the digit; zero uses 7+4.
  function automatic logic [4:0] ref_word(input int d);
    int         wt[5] = '{7, 4, 2, 1, 0};
    int         target;
    logic [4:0] w = '0;
    if (d > 9) return 5'b00000;
    target = (d == 0) ? 11 : d;
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        if (wt[i] + wt[j] == target) begin
          w = '0;
          w[4-i] = 1'b1;
          w[4-j] = 1'b1;
        end
    return w;
  endfunction

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b >= 6) return 1'b1;
    return m_code[5-b];
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 0;
      m_code   = '0;
      m_err    = 0;
    end else if (!m_active && in_valid) begin
      m_active = 1;
      m_pos    = 0;
      m_code   = ref_word(int'(digit));
      m_err    = (digit > 4'd9);
    end else begin
      m_err = 0;
      if (m_active) begin
        m_pos++;
        if (m_pos == 7 * CPB) m_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("tx", tx, exp_tx());
      check_val("busy", busy, m_active);
      check_val("in_ready", in_ready, (!m_active && rst_n));
      check_val("code_out", code_out, m_code);
      check_val("err", err, m_err);
    end
  end

  task automatic send(input logic [3:0] d, input bit hold, output int t_acc);
    bit ok = 0;
    digit    = d;
    in_valid = 1'b1;
    t_acc    = -1;
    for (int i = 0; i < 20 * CPB && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok    = 1;
        t_acc = cyc;
      end
    end
    if (!hold) in_valid = 1'b0;
    check_val("send_accepted", ok, 1);
  endtask

  initial begin
    int         t;
    int         t_prev;
    logic [6:0] seq;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    digit    = '0;
    @(posedge clk);
    #1;
    chk_en = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // idle after reset
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_val("idle_code", code_out, 5'b00000);
    check_val("idle_ready", in_ready, 1);
    check_val("idle_tx", tx, 1);

    // digit 7: bit sequence sampled mid-bit and return-to-ready timing
    send(4'd7, 0, t);
    seq = '0;
    for (int b = 0; b < 7; b++) begin
      repeat ((b == 0) ? 1 : CPB) @(negedge clk);
      if (b == 0) check_val("d7_code", code_out, 5'b10001);
      seq = {seq[5:0], tx};
    end
    check_val("d7_seq", seq, 7'b0100011);
    repeat (3) @(negedge clk);
    check_val("d7_ready_late", in_ready, 0);
    @(negedge clk);
    check_val("d7_ready_back", in_ready, 1);

    // back-to-back sweep with in_valid held
    t_prev = 0;
    for (int d = 0; d < 10; d++) begin
      send(4'(d), (d != 9), t);
      if (d > 0) check_val("b2b_gap", t - t_prev, 7 * CPB + 1);
      t_prev = t;
      @(negedge clk);
      check_val("two_hot", $countones(code_out), 2);
    end
    repeat (7 * CPB + 2) @(posedge clk);

    // non-BCD digit
    send(4'd12, 0, t);
    @(negedge clk);
    check_val("d12_err", err, 1);
    check_val("d12_code", code_out, 5'b00000);
    @(negedge clk);
    check_val("d12_err_once", err, 0);
    repeat (7 * CPB + 2) @(posedge clk);

    // pulse while busy is ignored
    send(4'd4, 0, t);
    repeat (5) @(posedge clk);
    #1;
    digit    = 4'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("busy_ignore_code", code_out, 5'b01001);
    repeat (7 * CPB + 2) @(posedge clk);
    @(negedge clk);
    check_val("busy_ignore_idle", busy, 0);

    // reset during data bit 2 of digit 5
    send(4'd5, 0, t);
    repeat (3 * CPB + 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_code", code_out, 5'b00000);
    send(4'd1, 0, t);
    @(negedge clk);
    check_val("post_rst_code", code_out, 5'b00011);
    repeat (7 * CPB + 2) @(posedge clk);

    // random traffic, including stray resets
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      rst_n    = ($urandom_range(0, 299) != 0);
      in_valid = ($urandom_range(0, 2) == 0);
      digit    = 4'($urandom_range(0, 15));
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (7 * CPB + 4) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
